// File: rtl/microp_copier_pkg.sv
// Shared definitions for the RAM copier Avalon-MM master.
//   MODE_*      : encodings of the 2-bit mode input
//   state_e     : FSM states (IDLE, RD, WR, FIN)
//   WORD_BYTES  : byte stride between consecutive words
package microp_copier_pkg;

  localparam logic [1:0] MODE_COPY  = 2'd0;
  localparam logic [1:0] MODE_FILL  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/microp_ram_copier.sv
// Avalon-MM (non-pipelined) master that copies, fills or checks a word-aligned
// range of the on-chip RAM.
//
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : 1-cycle job request, only accepted in IDLE
//   abort               : level, honoured at access boundaries
//   mode                : 0 COPY, 1 FILL, 2 CHECK, 3 reserved (error)
//   src_addr, dst_addr  : byte addresses, latched at start
//   len                 : word count, latched at start
//   pattern             : fill / compare word, latched at start
//   busy, done, error   : job status (done is a 1-cycle pulse in FIN)
//   mismatch_cnt        : saturating CHECK mismatch count
//   avm_*               : Avalon-MM master signals
//   dbg_state           : current FSM state for observation
//
// Handshake: an access is issued by holding avm_read or avm_write high (never
// both) together with address/data; it completes in the cycle where
// avm_waitrequest is low. All request signals are functions of registered
// state only, so they stay stable for as long as the slave stalls.
module microp_ram_copier
  import microp_copier_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 14,
  parameter int unsigned CNT_W  = 14
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    len,
  input  logic [DATA_W-1:0]   pattern,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [CNT_W-1:0]    mismatch_cnt,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest,
  output logic [1:0]          dbg_state
);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  pat_q, pat_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               error_q, error_d;
  logic [CNT_W-1:0]   mism_q, mism_d;
  logic               abort_q, abort_d;

  logic bad_params;
  logic abort_any;
  logic last_word;

  // Which addresses a mode uses decides which alignment faults count.
  always_comb begin
    bad_params = 1'b0;
    if (mode == MODE_RSVD) begin
      bad_params = 1'b1;
    end
    if ((mode == MODE_COPY || mode == MODE_CHECK) && src_addr[1:0] != 2'b00) begin
      bad_params = 1'b1;
    end
    if ((mode == MODE_COPY || mode == MODE_FILL) && dst_addr[1:0] != 2'b00) begin
      bad_params = 1'b1;
    end
  end

  // abort_q remembers an abort pulse that arrived between boundaries
  // (including one coinciding with the accepted start).
  assign abort_any = abort | abort_q;
  assign last_word = (cnt_q == LEN_W'(1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    rdata_d = rdata_q;
    error_d = error_q;
    mism_d  = mism_q;
    abort_d = abort_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = len;
          pat_d   = pattern;
          error_d = 1'b0;
          mism_d  = '0;
          abort_d = abort;
          if (bad_params) begin
            error_d = 1'b1;
            state_d = ST_FIN;
          end else if (len == '0) begin
            state_d = ST_FIN;
          end else if (mode == MODE_FILL) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end

      ST_RD: begin
        abort_d = abort_any;
        if (!avm_waitrequest) begin
          src_d = src_q + ADDR_W'(WORD_BYTES);
          if (mode_q == MODE_COPY) begin
            // The paired write always follows, even if abort is pending.
            rdata_d = avm_readdata;
            state_d = ST_WR;
          end else begin
            if (avm_readdata != pat_q) begin
              error_d = 1'b1;
              if (mism_q != {CNT_W{1'b1}}) begin
                mism_d = mism_q + CNT_W'(1);
              end
            end
            cnt_d = cnt_q - LEN_W'(1);
            if (abort_any) begin
              error_d = 1'b1;
              state_d = ST_FIN;
            end else if (last_word) begin
              state_d = ST_FIN;
            end
          end
        end
      end

      ST_WR: begin
        abort_d = abort_any;
        if (!avm_waitrequest) begin
          dst_d = dst_q + ADDR_W'(WORD_BYTES);
          cnt_d = cnt_q - LEN_W'(1);
          if (abort_any) begin
            error_d = 1'b1;
            state_d = ST_FIN;
          end else if (last_word) begin
            state_d = ST_FIN;
          end else if (mode_q == MODE_COPY) begin
            state_d = ST_RD;
          end
        end
      end

      ST_FIN: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      mism_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      mism_q  <= mism_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    avm_read       = (state_q == ST_RD);
    avm_write      = (state_q == ST_WR);
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    if (state_q == ST_RD) begin
      avm_address    = src_q;
      avm_byteenable = '1;
    end else if (state_q == ST_WR) begin
      avm_address    = dst_q;
      avm_byteenable = '1;
      avm_writedata  = (mode_q == MODE_COPY) ? rdata_q : pat_q;
    end
  end

  assign busy         = (state_q == ST_RD) || (state_q == ST_WR);
  assign done         = (state_q == ST_FIN);
  assign error        = error_q;
  assign mismatch_cnt = mism_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_microp_ram_copier.sv
module tb_microp_ram_copier;

  localparam int EW = 49; // {is_write, addr[15:0], data[31:0]}

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [13:0] len = '0;
  logic [31:0] pattern = '0;
  logic        busy, done, error;
  logic [13:0] mismatch_cnt;
  logic [15:0] avm_address;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest = 1'b0;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:16383];
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  bit rand_wait = 0;
  bit prev_stall = 0;
  logic [49:0] saved_req;
  int lat;

  microp_ram_copier dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .pattern(pattern),
    .busy(busy), .done(done), .error(error), .mismatch_cnt(mismatch_cnt),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  assign avm_readdata = mem[avm_address[15:2]];

  always @(posedge clk) begin
    #1;
    avm_waitrequest = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b0;
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'hD000_0000 ^ (i * 32'h0001_0203);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [31:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic push_rd(input logic [15:0] a);
    exp_q.push_back({1'b0, a, 32'h0});
  endtask

  // ---------------- bus monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] act;
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("held_stable", {14'd0, avm_read, avm_write, avm_address, avm_writedata},
              {14'd0, saved_req});
      end
      if (avm_read || avm_write) begin
        check("rw_excl", {63'd0, avm_read & avm_write}, 64'd0);
        check("byteenable", {60'd0, avm_byteenable}, 64'hF);
        if (!avm_waitrequest) begin
          act = {avm_write, avm_address, avm_write ? avm_writedata : 32'h0};
          if (exp_q.size() == 0) begin
            check("unexp_xfer", {15'd0, act}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            check("xfer", {15'd0, act}, {15'd0, exp_q.pop_front()});
          end
          if (avm_write) begin
            mem[avm_address[15:2]] = avm_writedata;
            wr_cnt++;
          end else begin
            rd_cnt++;
          end
        end
        prev_stall = avm_waitrequest;
        saved_req  = {avm_read, avm_write, avm_address, avm_writedata};
      end else begin
        prev_stall = 0;
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input logic [1:0] m, input logic [15:0] s, input logic [15:0] d,
                           input logic [13:0] l, input logic [31:0] p);
    done_cnt = 0;
    rd_cnt = 0;
    wr_cnt = 0;
    @(posedge clk);
    #1;
    mode = m; src_addr = s; dst_addr = d; len = l; pattern = p; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns cycles from the start cycle to the done cycle.
  task automatic wait_done(output int latency);
    int k;
    k = 1;
    while (k < 3000) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    if (!done) begin
      check("done_timeout", {63'd0, done}, 64'd1);
    end
    check("busy_in_fin", {63'd0, busy}, 64'd0);
    latency = k;
    @(negedge clk);
    check("done_pulse", {63'd0, done}, 64'd0);
    check("done_count", 64'(done_cnt), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = init_word(i);

    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_mism", {50'd0, mismatch_cnt}, 64'd0);
    check("rst_rdwr", {62'd0, avm_read, avm_write}, 64'd0);
    check("rst_addr", {48'd0, avm_address}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: FILL, zero wait states, exact latency
    for (int i = 0; i < 4; i++) push_wr(16'h0100 + 16'(4 * i), 32'hA5A5_A5A5);
    start_job(2'd1, 16'h0000, 16'h0100, 14'd4, 32'hA5A5_A5A5);
    wait_done(lat);
    check("fill_latency", 64'(lat), 64'd5);
    check("fill_error", {63'd0, error}, 64'd0);
    check("fill_wr_cnt", 64'(wr_cnt), 64'd4);

    // 2: COPY with random waitrequest
    rand_wait = 1;
    for (int i = 0; i < 3; i++) begin
      push_rd(16'(4 * i));
      push_wr(16'h0200 + 16'(4 * i), init_word(i));
    end
    start_job(2'd0, 16'h0000, 16'h0200, 14'd3, 32'h0);
    wait_done(lat);
    for (int i = 0; i < 3; i++) check("copy_mem", {32'd0, mem[16'h80 + 16'(i)]}, {32'd0, init_word(i)});
    check("copy_error", {63'd0, error}, 64'd0);
    rand_wait = 0;

    // 3: CHECK with one corrupted word
    mem[16'h0104 >> 2] = 32'h1234_5678;
    for (int i = 0; i < 4; i++) push_rd(16'h0100 + 16'(4 * i));
    start_job(2'd2, 16'h0100, 16'h0000, 14'd4, 32'hA5A5_A5A5);
    wait_done(lat);
    check("chk_latency", 64'(lat), 64'd5);
    check("chk_mism", {50'd0, mismatch_cnt}, 64'd1);
    check("chk_error", {63'd0, error}, 64'd1);

    // 4: degenerate parameters, no bus traffic
    start_job(2'd1, 16'h0000, 16'h0300, 14'd0, 32'h1);
    wait_done(lat);
    check("len0_latency", 64'(lat), 64'd1);
    check("len0_error", {63'd0, error}, 64'd0);
    check("len0_mism_cleared", {50'd0, mismatch_cnt}, 64'd0);
    start_job(2'd3, 16'h0000, 16'h0300, 14'd4, 32'h1);
    wait_done(lat);
    check("mode3_error", {63'd0, error}, 64'd1);
    start_job(2'd0, 16'h0002, 16'h0300, 14'd4, 32'h1);
    wait_done(lat);
    check("unaligned_error", {63'd0, error}, 64'd1);
    check("param_no_bus", 64'(rd_cnt + wr_cnt), 64'd0);

    // 5: abort right after the 2nd read is accepted
    for (int i = 0; i < 2; i++) begin
      push_rd(16'h0400 + 16'(4 * i));
      push_wr(16'h0500 + 16'(4 * i), init_word(16'h100 + i));
    end
    start_job(2'd0, 16'h0400, 16'h0500, 14'd8, 32'h0);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    wait_done(lat);
    abort = 1'b0;
    check("abort_error", {63'd0, error}, 64'd1);
    check("abort_rd_cnt", 64'(rd_cnt), 64'd2);
    check("abort_wr_cnt", 64'(wr_cnt), 64'd2);

    // 6a: FILL across the address wrap
    push_wr(16'hFFFC, 32'h5A5A_0001);
    push_wr(16'h0000, 32'h5A5A_0001);
    start_job(2'd1, 16'h0000, 16'hFFFC, 14'd2, 32'h5A5A_0001);
    wait_done(lat);
    check("wrap_latency", 64'(lat), 64'd3);

    // 6b: reset in the middle of a COPY
    for (int i = 0; i < 8; i++) begin
      push_rd(16'h0600 + 16'(4 * i));
      push_wr(16'h0700 + 16'(4 * i), init_word(16'h180 + i));
    end
    start_job(2'd0, 16'h0600, 16'h0700, 14'd8, 32'h0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("rst_mid_rdwr", {62'd0, avm_read, avm_write}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_no_done", 64'(done_cnt), 64'd0);
    check("rst_mid_state", {62'd0, dbg_state}, 64'd0);
    check("rst_mid_queue", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
